// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller with frame-aligned digit updates
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    output logic [3:0]                    nibble,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done,
    output logic                          pending
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(PRESCALE + BLANK_CYCLES + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    // With no blanking, each digit slot starts directly in SHOW.
    localparam logic [1:0]    FIRST      = (BLANK_CYCLES == 0) ? SHOW : BLANK;
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    logic [1:0]              state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx_nxt;
    logic [4*NUM_DIGITS-1:0] active, active_nxt, shadow;
    logic                    swap, fd_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = digit_idx;
        swap      = 1'b0;
        fd_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (enable) begin
                    state_nxt = FIRST;
                    swap      = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else if (cnt == SHOW_LAST) begin
                    state_nxt = FIRST;
                    cnt_nxt   = '0;
                    if (digit_idx == LAST_IDX) begin
                        idx_nxt = '0;
                        swap    = 1'b1;
                        fd_nxt  = 1'b1;
                    end else begin
                        idx_nxt = digit_idx + IW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
        active_nxt = (swap && pending) ? shadow : active;
    end

    // Outputs are computed from next-state values so they line up with the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            digit_idx  <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            nibble     <= '0;
            an_n       <= '1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            digit_idx  <= idx_nxt;
            active     <= active_nxt;
            frame_done <= fd_nxt;
            if (load) begin
                shadow  <= digits_in;
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
            nibble <= active_nxt[4*idx_nxt +: 4];
            if (state_nxt == SHOW && digit_mask[idx_nxt])
                an_n <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nxt);
            else
                an_n <= '1;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a frame-timeline model
module tb_seg_scan_ctrl;

    localparam int NUM   = 4;
    localparam int PRE   = 4;
    localparam int BLK   = 1;
    localparam int SLOT  = BLK + PRE;
    localparam int FRAME = NUM * SLOT;
    localparam logic [11:0] RST_EXP = {4'h0, 4'hF, 2'd0, 1'b0, 1'b0};

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  digit_mask;
    logic [3:0]  nibble;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        frame_done;
    logic        pending;
    logic [11:0] outs;

    seg_scan_ctrl #(.NUM_DIGITS(NUM), .PRESCALE(PRE), .BLANK_CYCLES(BLK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .digit_mask (digit_mask),
        .nibble     (nibble),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .pending    (pending)
    );

    assign outs = {nibble, an_n, digit_idx, frame_done, pending};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fd = -1;

    bit          m_run;
    int          m_pos;
    logic [15:0] m_act;
    logic [15:0] m_sh;
    bit          m_pend;
    bit          m_fd;
    logic [3:0]  m_mask;
    logic [11:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model of the frame timeline: m_pos counts clocks since frame start.
    task automatic model_update();
        bit sw;
        sw     = 1'b0;
        m_fd   = 1'b0;
        m_mask = digit_mask;
        if (!rst_n) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_act  = '0;
            m_sh   = '0;
            m_pend = 1'b0;
        end else begin
            if (!m_run) begin
                if (enable) begin
                    m_run = 1'b1;
                    m_pos = 0;
                    sw    = 1'b1;
                end
            end else if (!enable) begin
                m_run = 1'b0;
                m_pos = 0;
            end else begin
                m_pos++;
                if (m_pos == FRAME) begin
                    m_pos = 0;
                    m_fd  = 1'b1;
                    sw    = 1'b1;
                end
            end
            if (sw && m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end
            if (load) begin
                m_sh   = digits_in;
                m_pend = 1'b1;
            end
        end
    endtask

    function automatic logic [11:0] model_expect();
        int d;
        logic [3:0] an;
        d  = m_run ? m_pos / SLOT : 0;
        an = 4'hF;
        if (m_run && (m_pos % SLOT) >= BLK && m_mask[d])
            an[d] = 1'b0;
        return {m_act[4*d +: 4], an, 2'(d), m_fd, m_pend};
    endfunction

    task automatic tick();
        logic [11:0] e;
        @(posedge clk);
        model_update();
        sb_q.push_back(model_expect());
        #1;
        e = sb_q.pop_front();
        check("cyc", outs, e);
        check("onehot", $countones(~an_n) <= 1, 1);
        cyc++;
        if (!rst_n || !enable) begin
            last_fd = -1;
        end else if (frame_done) begin
            if (last_fd >= 0)
                check("fd_period", cyc - last_fd, FRAME);
            last_fd = cyc;
        end
    endtask

    task automatic wait_pos(input int p, input string tag);
        int n;
        n = 0;
        while (!(m_run && m_pos == p) && n < 100) begin
            tick();
            n++;
        end
        check(tag, n < 100, 1);
    endtask

    initial begin
        int lit02;
        clk        = 1'b0;
        rst_n      = 1'b1;
        enable     = 1'b1;
        load       = 1'b0;
        digits_in  = '0;
        digit_mask = 4'hF;
        #1 rst_n = 1'b0;
        #1 check("rst_async0", outs, RST_EXP);
        repeat (3) tick();

        rst_n  = 1'b1;
        enable = 1'b0;
        tick();
        load      = 1'b1;
        digits_in = 16'h4321;
        tick();
        load = 1'b0;
        check("pend_set", pending, 1);
        enable = 1'b1;
        repeat (45) tick();

        wait_pos(7, "wait_mid1");
        load      = 1'b1;
        digits_in = 16'hABCD;
        tick();
        digits_in = 16'h00EF;
        tick();
        load = 1'b0;
        repeat (30) tick();

        wait_pos(3, "wait_mid2");
        load      = 1'b1;
        digits_in = 16'h9999;
        tick();
        load = 1'b0;
        wait_pos(0, "wait_fd");
        check("fd_hi", frame_done, 1);
        load      = 1'b1;
        digits_in = 16'h5555;
        tick();
        load = 1'b0;
        check("pend_5555", pending, 1);
        repeat (45) tick();

        wait_pos(10, "wait_mid3");
        load      = 1'b1;
        digits_in = 16'h1111;
        tick();
        load = 1'b0;
        wait_pos(FRAME - 1, "wait_last");
        load      = 1'b1;
        digits_in = 16'h7777;
        tick();
        load = 1'b0;
        check("pend_kept", pending, 1);
        check("swap_old", nibble, 4'h1);
        repeat (25) tick();

        digit_mask = 4'b1010;
        tick();
        lit02 = 0;
        repeat (40) begin
            tick();
            if (!an_n[0] || !an_n[2])
                lit02++;
        end
        check("mask_dark", lit02, 0);
        digit_mask = 4'hF;

        wait_pos(12, "wait_d2");
        enable = 1'b0;
        tick();
        check("dis_an", an_n, 4'hF);
        check("dis_idx", digit_idx, 0);
        repeat (3) tick();
        enable = 1'b1;
        repeat (25) tick();

        load      = 1'b1;
        digits_in = 16'h2468;
        tick();
        load = 1'b0;
        wait_pos(7, "wait_show");
        #3 rst_n = 1'b0;
        #1 check("arst_out", outs, RST_EXP);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Shares the single nibble-to-segment decoder path between NUM_DIGITS digits. Each cycle it presents one 4-bit digit value to the decoder and enables only the matching digit anode.
- Captures new display contents through a load strobe and applies them only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clock cycles each digit is lit (>=1).
- BLANK_CYCLES, 2, clock cycles all anodes are off before each digit (0 = no blanking).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  scanning enabled; low forces display dark.
- load  input  1  single-cycle strobe; captures digits_in.
- digits_in  input  4*NUM_DIGITS  digit values; digit k = bits [4k+3:4k].
- digit_mask  input  NUM_DIGITS  1 = digit k may light; sampled live.
- nibble  output  4  value sent to the segment decoder.
- an_n  output  NUM_DIGITS  active-low anode enables; at most one bit low.
- digit_idx  output  $clog2(NUM_DIGITS)  index of the current digit.
- frame_done  output  1  one-cycle pulse at the end of the last digit.
- pending  output  1  captured data is waiting for the next frame.

Behaviour:
- Reset: clk is single clock; rst_n async active-low. While rst_n=0, all of the following hold immediately, independent of clk:
  - state=IDLE, nibble=0, an_n=all 1, digit_idx=0, frame_done=0, pending=0.
  - Active and shadow digit registers = 0; cycle counter = 0.
- All outputs are registered. No combinational input-to-output paths.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - an_n=all 1; digit_idx=0; counter=0.
  - On enable=1, go to BLANK (or to SHOW if BLANK_CYCLES=0) at digit 0.
  - Perform the frame-start swap on that transition.
- BLANK:
  - an_n=all 1; nibble=active[digit_idx].
  - Lasts exactly BLANK_CYCLES clocks, then go to SHOW; counter resets.
- SHOW:
  - an_n[digit_idx]=0 only if digit_mask[digit_idx]=1, else all 1; nibble=active[digit_idx].
  - Lasts exactly PRESCALE clocks.
  - At the end, if digit_idx<NUM_DIGITS-1: increment digit_idx and go to BLANK/SHOW.
  - At the end, if digit_idx=NUM_DIGITS-1:
    - wrap digit_idx to 0; frame_done=1 for exactly that one cycle;
    - perform the frame-start swap; go to BLANK/SHOW.
- Frame length = NUM_DIGITS*(BLANK_CYCLES+PRESCALE) clocks.
- Load/swap handshake:
  - load=1 writes digits_in to the shadow register and sets pending=1. Accepted in any state, including IDLE and enable=0.
  - Repeated loads before a swap overwrite the shadow; last load wins.
  - Frame-start swap: if pending=1, copy shadow to active and clear pending.
  - load in the same cycle as a swap: the swap uses the shadow value from before that edge. The new data goes to the shadow and pending stays 1, so it is applied at the next frame.
- enable=0 while in BLANK or SHOW: next edge goes to IDLE; an_n=all 1; digit_idx=0; counter cleared; no frame_done. Active, shadow and pending are kept.
- digit_mask changes take effect on the next edge. They never alter timing.
- Invariant: an_n never has more than one bit low; checked every cycle.

Test Plan (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1):
- Reset, then hold rst_n=0 for 3 clocks with enable=1 -> an_n=4'b1111, nibble=0, pending=0, frame_done=0 throughout.
- Release reset, pulse load with digits_in=16'h4321, then enable=1 -> pending falls at frame start; an_n sequence 1111(1) / 1110(4) / 1111(1) / 1101(4) / …; nibble shows 1,2,3,4 per digit; frame_done pulses every 20 clocks.
- Mid-frame, load 16'hABCD then 16'h00EF -> display keeps 4321 until the frame end, then shows F,E,0,0; ABCD never appears.
- load coinciding with the frame_done cycle, value 16'h5555 while 16'h9999 is pending -> next frame shows 9999, the following frame shows 5555.
- digit_mask=4'b1010 -> digits 0 and 2 are never lit (their an_n bits stay 1); timing is unchanged (frame still 20 clocks).
- Drop enable during SHOW of digit 2 -> next cycle an_n=1111 and digit_idx=0. Re-enable -> the scan restarts at digit 0 with the same active data. Async rst_n pulse mid-SHOW -> outputs go to reset values before the next clk edge.
